// File: rtl/frame_clip_stats_if.sv
// Source-stream pixel bus into the histogram clip stage and its level/status outputs.
interface frame_clip_stats_if #(
  parameter int CNT_W = 20
);
  logic [7:0]       isrc_data;
  logic             isrc_vs;
  logic             isrc_de;
  logic [7:0]       omin;
  logic [7:0]       omax;
  logic             ovalid;
  logic [CNT_W-1:0] ototal;
  logic             obusy;
  logic             ooverrun;

  modport master (
    output isrc_data, isrc_vs, isrc_de,
    input  omin, omax, ovalid, ototal, obusy, ooverrun
  );

  modport slave (
    input  isrc_data, isrc_vs, isrc_de,
    output omin, omax, ovalid, ototal, obusy, ooverrun
  );
endinterface

// File: rtl/frame_clip_stats.sv
// Per-frame 256-bin luma histogram; scanned in blanking to derive percentile-clipped
// black/white levels for the contrast-stretch stage.
module frame_clip_stats #(
  parameter bit POLARITY  = 1'b1,
  parameter int CNT_W     = 20,
  parameter int LOW_CLIP  = 64,
  parameter int HIGH_CLIP = 64
) (
  input  logic              isrc_clk,
  input  logic              isrc_rst_n,
  frame_clip_stats_if.slave bus
);
  localparam int CW = CNT_W + 1;

  typedef enum logic [2:0] {S_INIT, S_WAIT, S_ACCUM, S_DRAIN, S_SCAN} state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_addr, w_addr_nxt;
  logic             w_mem_clr, w_scan_rd;
  logic             r_vs, w_vs_stb;
  logic             w_pix_acc, w_pix_drop, w_vs_drop;

  logic [CNT_W-1:0] r_mem [256];
  logic [CNT_W-1:0] r_rd;
  logic [7:0]       w_rd_addr, w_wa;
  logic             w_we;
  logic [CNT_W-1:0] w_wd;

  logic             r_p1_v, r_lw_v;
  logic [7:0]       r_p1_addr, r_lw_addr;
  logic [CNT_W-1:0] r_lw_val, w_base, w_inc;

  logic [CNT_W-1:0] r_total, r_ftotal, r_stot, r_ototal;
  logic [CW-1:0]    r_cum, w_cum_nxt, w_hi_thr;
  logic [CW:0]      w_sum;
  logic             w_hi_few;
  logic             r_lo_f, r_hi_f, w_lo_f_n, w_hi_f_n;
  logic [7:0]       r_lo, r_hi, w_lo_n, w_hi_n;
  logic             r_sc_v, r_fin, r_ovalid, r_ovr;
  logic [7:0]       r_sc_bin, w_fmin, w_fmax, r_smin, r_smax, r_omin, r_omax;

  assign w_vs_stb   = (bus.isrc_vs == POLARITY) && (r_vs != POLARITY);
  assign w_pix_acc  = bus.isrc_de && (r_state == S_ACCUM) && !w_vs_stb;
  assign w_pix_drop = bus.isrc_de && ((r_state inside {S_INIT, S_DRAIN, S_SCAN}) ||
                                      ((r_state == S_ACCUM) && w_vs_stb));
  assign w_vs_drop  = w_vs_stb && (r_state inside {S_DRAIN, S_SCAN});

  always_ff @(posedge isrc_clk or negedge isrc_rst_n) begin
    if (!isrc_rst_n) begin
      r_state <= S_INIT;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  // r_addr walks the bins in INIT and SCAN and times the two DRAIN cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_mem_clr   = 1'b0;
    w_scan_rd   = 1'b0;
    case (r_state)
      S_INIT: begin
        w_mem_clr  = 1'b1;
        w_addr_nxt = r_addr + 8'd1;
        if (r_addr == 8'hFF) w_state_nxt = S_WAIT;
      end
      S_WAIT:  if (w_vs_stb) w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_vs_stb) begin
        w_state_nxt = S_DRAIN;
        w_addr_nxt  = '0;
      end
      S_DRAIN: begin
        w_addr_nxt = r_addr + 8'd1;
        if (r_addr == 8'd1) begin
          w_state_nxt = S_SCAN;
          w_addr_nxt  = '0;
        end
      end
      S_SCAN: begin
        w_scan_rd  = 1'b1;
        w_mem_clr  = 1'b1;
        w_addr_nxt = r_addr + 8'd1;
        if (r_addr == 8'hFF) w_state_nxt = S_ACCUM;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  // A read issued in the same cycle as the previous pixel's write returns the old
  // count, so the last written value is forwarded when the bins match.
  always_comb begin
    w_base    = (r_lw_v && (r_lw_addr == r_p1_addr)) ? r_lw_val : r_rd;
    w_inc     = (&w_base) ? w_base : w_base + CNT_W'(1);
    w_rd_addr = (r_state == S_SCAN) ? r_addr : bus.isrc_data;
    w_we      = 1'b0;
    w_wa      = r_addr;
    w_wd      = '0;
    if (w_mem_clr) begin
      w_we = 1'b1;
    end else if (r_p1_v) begin
      w_we = 1'b1;
      w_wa = r_p1_addr;
      w_wd = w_inc;
    end
  end

  always_ff @(posedge isrc_clk) begin
    if (w_we) r_mem[w_wa] <= w_wd;
    r_rd <= r_mem[w_rd_addr];
  end

  always_comb begin
    w_sum     = {1'b0, r_cum} + {2'b00, r_rd};
    w_cum_nxt = w_sum[CW] ? '1 : w_sum[CW-1:0];
    w_hi_thr  = CW'(r_ftotal) - CW'(HIGH_CLIP);
    w_hi_few  = (CW'(r_ftotal) <= CW'(HIGH_CLIP));
    w_lo_f_n  = r_lo_f;
    w_lo_n    = r_lo;
    w_hi_f_n  = r_hi_f;
    w_hi_n    = r_hi;
    if (r_sc_v && !r_lo_f && (w_cum_nxt > CW'(LOW_CLIP))) begin
      w_lo_f_n = 1'b1;
      w_lo_n   = r_sc_bin;
    end
    if (r_sc_v && !r_hi_f && (w_cum_nxt >= w_hi_thr)) begin
      w_hi_f_n = 1'b1;
      w_hi_n   = r_sc_bin;
    end
    w_fmin = w_lo_f_n ? w_lo_n : 8'h00;
    w_fmax = (w_hi_few || !w_hi_f_n) ? 8'hFF : w_hi_n;
    if (w_fmax < w_fmin) w_fmax = w_fmin;
    if (r_ftotal == '0) begin
      w_fmin = 8'h00;
      w_fmax = 8'hFF;
    end
  end

  always_ff @(posedge isrc_clk or negedge isrc_rst_n) begin
    if (!isrc_rst_n) begin
      r_vs      <= 1'b0;
      r_p1_v    <= 1'b0;
      r_p1_addr <= '0;
      r_lw_v    <= 1'b0;
      r_lw_addr <= '0;
      r_lw_val  <= '0;
      r_total   <= '0;
      r_ftotal  <= '0;
      r_cum     <= '0;
      r_lo_f    <= 1'b0;
      r_hi_f    <= 1'b0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_sc_v    <= 1'b0;
      r_sc_bin  <= '0;
      r_fin     <= 1'b0;
      r_smin    <= '0;
      r_smax    <= '1;
      r_stot    <= '0;
      r_omin    <= '0;
      r_omax    <= '1;
      r_ototal  <= '0;
      r_ovalid  <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_vs      <= bus.isrc_vs;
      r_p1_v    <= w_pix_acc;
      r_p1_addr <= bus.isrc_data;
      r_lw_v    <= r_p1_v;
      r_lw_addr <= r_p1_addr;
      r_lw_val  <= w_inc;
      r_ovr     <= w_pix_drop | w_vs_drop;
      if (w_pix_acc && !(&r_total)) r_total <= r_total + CNT_W'(1);
      r_sc_v   <= w_scan_rd;
      r_sc_bin <= r_addr;
      if (r_sc_v) begin
        r_cum  <= w_cum_nxt;
        r_lo_f <= w_lo_f_n;
        r_lo   <= w_lo_n;
        r_hi_f <= w_hi_f_n;
        r_hi   <= w_hi_n;
      end
      // Results are staged on the last bin so a strobe arriving right after SCAN
      // can restart the scan state without corrupting the pending report.
      r_fin <= r_sc_v && (r_sc_bin == 8'hFF);
      if (r_sc_v && (r_sc_bin == 8'hFF)) begin
        r_smin <= w_fmin;
        r_smax <= w_fmax;
        r_stot <= r_ftotal;
      end
      r_ovalid <= r_fin;
      if (r_fin) begin
        r_omin   <= r_smin;
        r_omax   <= r_smax;
        r_ototal <= r_stot;
      end
      if (w_vs_stb && (r_state inside {S_WAIT, S_ACCUM})) r_total <= '0;
      if (w_vs_stb && (r_state == S_ACCUM)) begin
        r_ftotal <= r_total;
        r_cum    <= '0;
        r_lo_f   <= 1'b0;
        r_hi_f   <= 1'b0;
      end
    end
  end

  assign bus.omin     = r_omin;
  assign bus.omax     = r_omax;
  assign bus.ototal   = r_ototal;
  assign bus.ovalid   = r_ovalid;
  assign bus.ooverrun = r_ovr;
  assign bus.obusy    = (r_state inside {S_INIT, S_DRAIN, S_SCAN}) | r_sc_v | r_fin | r_ovalid;
endmodule

// File: tb/tb_frame_clip_stats.sv
// Directed bench: two instances (clip 0/0 and 4/4) fed the same stream, hand-computed levels.
module tb_frame_clip_stats;
  localparam int CNT_W = 20;

  logic       isrc_clk;
  logic       isrc_rst_n;
  logic [7:0] r_data;
  logic       r_vs;
  logic       r_de;
  int         cyc;
  int         t_vs;
  int         n_vec;
  int         n_err;

  frame_clip_stats_if #(.CNT_W(CNT_W)) if_a ();
  frame_clip_stats_if #(.CNT_W(CNT_W)) if_b ();

  assign if_a.isrc_data = r_data;
  assign if_a.isrc_vs   = r_vs;
  assign if_a.isrc_de   = r_de;
  assign if_b.isrc_data = r_data;
  assign if_b.isrc_vs   = r_vs;
  assign if_b.isrc_de   = r_de;

  frame_clip_stats #(.POLARITY(1'b1), .CNT_W(CNT_W), .LOW_CLIP(0), .HIGH_CLIP(0)) u_dut_a (
    .isrc_clk   (isrc_clk),
    .isrc_rst_n (isrc_rst_n),
    .bus        (if_a)
  );

  frame_clip_stats #(.POLARITY(1'b1), .CNT_W(CNT_W), .LOW_CLIP(4), .HIGH_CLIP(4)) u_dut_b (
    .isrc_clk   (isrc_clk),
    .isrc_rst_n (isrc_rst_n),
    .bus        (if_b)
  );

  initial isrc_clk = 1'b0;
  always #5 isrc_clk = ~isrc_clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge isrc_clk);
      #1;
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pix(input logic [7:0] v);
    r_data = v;
    r_de   = 1'b1;
    tick();
    r_de   = 1'b0;
  endtask

  task automatic strobe(input logic de, input logic [7:0] v);
    r_vs   = 1'b1;
    r_de   = de;
    r_data = v;
    t_vs   = cyc;
    tick();
    r_vs   = 1'b0;
    r_de   = 1'b0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic results(input string tag, input int amin, input int amax, input int atot,
                         input int bmin, input int bmax, input int btot);
    run_to(t_vs + 260);
    chk({tag, ".a_vld_early"}, 32'(if_a.ovalid), 0);
    tick();
    chk({tag, ".a_vld"}, 32'(if_a.ovalid), 1);
    chk({tag, ".b_vld"}, 32'(if_b.ovalid), 1);
    chk({tag, ".a_min"}, 32'(if_a.omin), amin);
    chk({tag, ".a_max"}, 32'(if_a.omax), amax);
    chk({tag, ".a_tot"}, 32'(if_a.ototal), atot);
    chk({tag, ".b_min"}, 32'(if_b.omin), bmin);
    chk({tag, ".b_max"}, 32'(if_b.omax), bmax);
    chk({tag, ".b_tot"}, 32'(if_b.ototal), btot);
    tick();
    chk({tag, ".a_vld_late"}, 32'(if_a.ovalid), 0);
    chk({tag, ".a_min_hold"}, 32'(if_a.omin), amin);
    chk({tag, ".a_busy_low"}, 32'(if_a.obusy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    cyc        = 0;
    n_vec      = 0;
    n_err      = 0;
    r_data     = '0;
    r_vs       = 1'b0;
    r_de       = 1'b0;
    isrc_rst_n = 1'b0;
    tick(3);
    chk("rst.min",  32'(if_a.omin), 0);
    chk("rst.max",  32'(if_a.omax), 255);
    chk("rst.tot",  32'(if_a.ototal), 0);
    chk("rst.vld",  32'(if_a.ovalid), 0);
    chk("rst.ovr",  32'(if_a.ooverrun), 0);
    chk("rst.busy", 32'(if_a.obusy), 1);
    isrc_rst_n = 1'b1;
    tick(260);
    chk("wait.busy", 32'(if_a.obusy), 0);
    for (int i = 0; i < 3; i++) begin
      pix(8'd200);
      chk("wait.silent", 32'(if_a.ooverrun), 0);
    end

    // 4x4 ramp 10..25
    strobe(1'b0, 8'd0);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) pix(8'(10 + 4 * r + c));
      tick(2);
    end
    strobe(1'b0, 8'd0);
    run_to(t_vs + 100);
    chk("f0.busy_scan", 32'(if_a.obusy), 1);
    results("f0_ramp", 10, 25, 16, 14, 21, 16);

    // outliers at both ends
    pix(8'd0);
    pix(8'd0);
    repeat (1000) pix(8'd100);
    pix(8'd255);
    pix(8'd255);
    strobe(1'b0, 8'd0);
    results("f1_outlier", 0, 255, 1004, 100, 100, 1004);

    // back-to-back same and alternating values
    repeat (64) pix(8'd77);
    pix(8'd5);
    pix(8'd5);
    pix(8'd6);
    pix(8'd5);
    strobe(1'b0, 8'd0);
    results("f2_b2b", 5, 77, 68, 77, 77, 68);

    // empty frame
    strobe(1'b0, 8'd0);
    chk("f3.ovr", 32'(if_a.ooverrun), 0);
    results("f3_empty", 0, 255, 0, 0, 255, 0);

    // drops: pixel in strobe cycle, pixel and VS during SCAN
    pix(8'd50);
    pix(8'd60);
    pix(8'd70);
    strobe(1'b1, 8'd90);
    chk("f4.drop_stb_pix", 32'(if_a.ooverrun), 1);
    chk("f4.busy_drain",   32'(if_a.obusy), 1);
    tick();
    chk("f4.ovr_clear",    32'(if_a.ooverrun), 0);
    run_to(t_vs + 50);
    r_data = 8'd33;
    r_de   = 1'b1;
    tick();
    r_de   = 1'b0;
    chk("f4.drop_scan_pix", 32'(if_a.ooverrun), 1);
    tick();
    chk("f4.ovr_pulse", 32'(if_a.ooverrun), 0);
    run_to(t_vs + 100);
    r_vs = 1'b1;
    tick();
    r_vs = 1'b0;
    chk("f4.drop_scan_vs", 32'(if_a.ooverrun), 1);
    results("f4_drop", 50, 70, 3, 0, 255, 3);

    // reset mid-SCAN; bin 150 is not yet scanned at T+150
    pix(8'd150);
    pix(8'd150);
    strobe(1'b0, 8'd0);
    run_to(t_vs + 150);
    #2;
    isrc_rst_n = 1'b0;
    #1;
    chk("f5.rst_min",  32'(if_a.omin), 0);
    chk("f5.rst_max",  32'(if_a.omax), 255);
    chk("f5.rst_tot",  32'(if_a.ototal), 0);
    chk("f5.rst_vld",  32'(if_a.ovalid), 0);
    chk("f5.rst_busy", 32'(if_a.obusy), 1);
    tick(2);
    isrc_rst_n = 1'b1;
    tick(260);
    chk("f5.wait_busy", 32'(if_a.obusy), 0);
    strobe(1'b0, 8'd0);
    for (int i = 0; i < 5; i++) pix(8'(160 + i));
    strobe(1'b0, 8'd0);
    results("f6_after_rst", 160, 164, 5, 164, 164, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
